// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the debug module's single DMI target port among NUM_REQ masters.
// Define DMI_ARBITER_TIMEOUT_EN to abort transactions whose dmi_ready never arrives.
module dmi_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [7*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [31:0]           req_rdata,
    output logic                  req_err,
    output logic                  dmi_valid,
    input  logic                  dmi_ready,
    output logic                  dmi_write,
    output logic [6:0]            dmi_addr,
    output logic [31:0]           dmi_wdata,
    input  logic [31:0]           dmi_rdata
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dmi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] ready_d;
    logic [DW-1:0]   rdata_d;
    logic            valid_d;
    logic            write_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

`ifdef DMI_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            err_d;
`endif

    // Round-robin search starting just after the last granted requester
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        ready_d   = '0;
        rdata_d   = req_rdata;
        valid_d   = dmi_valid;
        write_d   = dmi_write;
        addr_d    = dmi_addr;
        wdata_d   = dmi_wdata;
`ifdef DMI_ARBITER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d   = pick_idx;
                    rr_ptr_d  = pick_idx;
                    write_d   = req_write[pick_idx];
                    addr_d    = req_addr[AW*pick_idx +: AW];
                    wdata_d   = req_wdata[DW*pick_idx +: DW];
                    valid_d   = 1'b1;
                    state_d   = ISSUE;
`ifdef DMI_ARBITER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ISSUE: begin
                if (dmi_valid && dmi_ready) begin
                    if (!dmi_write) begin
                        rdata_d = dmi_rdata;
                    end
                    valid_d          = 1'b0;
                    ready_d[grant_q] = 1'b1;
                    state_d          = RESP;
                end
`ifdef DMI_ARBITER_TIMEOUT_EN
                // Abort on the cycle the wait count reaches TIMEOUT_CYCLES
                else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    valid_d          = 1'b0;
                    rdata_d          = '0;
                    err_d            = 1'b1;
                    ready_d[grant_q] = 1'b1;
                    state_d          = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= IW'(NUM_REQ - 1);
            req_ready <= '0;
            req_rdata <= '0;
            dmi_valid <= 1'b0;
            dmi_write <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            req_ready <= ready_d;
            req_rdata <= rdata_d;
            dmi_valid <= valid_d;
            dmi_write <= write_d;
            dmi_addr  <= addr_d;
            dmi_wdata <= wdata_d;
        end
    end

`ifdef DMI_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
            req_err   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            req_err   <= err_d;
        end
    end
`else
    assign req_err = 1'b0;
`endif

endmodule
